// File: rtl/pe_pkg.sv
// Shared definitions for the fixed-point PE family: default geometry, slot/result
// types and a round/saturate helper. PE_ROUND_EVEN_EN selects round-half-to-even.
package pe_pkg;

  localparam int PE_INT_BITS   = 7;
  localparam int PE_FRAC_BITS  = 9;
  localparam int PE_NUM_ACC    = 8;
  localparam int PE_GUARD_BITS = 4;
  localparam int PE_OUT_DEPTH  = 2;

  localparam int PE_W      = PE_INT_BITS + PE_FRAC_BITS;
  localparam int PE_ACC_W  = 2 * PE_W + PE_GUARD_BITS;
  localparam int PE_SLOT_W = $clog2(PE_NUM_ACC);

  typedef logic [PE_SLOT_W-1:0] slot_t;

  typedef struct packed {
    logic [PE_W-1:0] data;
    slot_t           slot;
    logic            sat;
  } pe_result_t;

  // Round an accumulator of the default geometry back to Q(INT.FRAC) and clip it.
  function automatic pe_result_t round_sat(input logic signed [PE_ACC_W-1:0] acc,
                                           input slot_t slot);
    logic [PE_ACC_W:0]        one;
    logic [PE_ACC_W:0]        half;
    logic signed [PE_ACC_W:0] ext;
    logic signed [PE_ACC_W:0] biased;
    logic signed [PE_ACC_W:0] shifted;
    logic [PE_ACC_W-PE_W+1:0] hi;
    pe_result_t               r;
    one  = {{PE_ACC_W{1'b0}}, 1'b1};
    half = one << (PE_FRAC_BITS - 1);
    ext  = {acc[PE_ACC_W-1], acc};
`ifdef PE_ROUND_EVEN_EN
    biased = ext + (half - one) + {{PE_ACC_W{1'b0}}, ext[PE_FRAC_BITS]};
`else
    biased = ext + half;
`endif
    shifted = biased >>> PE_FRAC_BITS;
    hi      = shifted[PE_ACC_W:PE_W-1];
    r.slot  = slot;
    r.sat   = !((&hi) || !(|hi));
    if (r.sat)
      r.data = shifted[PE_ACC_W] ? {1'b1, {(PE_W-1){1'b0}}} : {1'b0, {(PE_W-1){1'b1}}};
    else
      r.data = shifted[PE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Combinational round-then-saturate from a wide accumulator to a W-bit result.
// PE_ROUND_EVEN_EN selects round-half-to-even; otherwise round-half-up.
module pe_round_sat #(
  parameter int IN_W      = 36,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 9
) (
  input  logic signed [IN_W-1:0] acc_in,
  output logic [OUT_W-1:0]       data_out,
  output logic                   sat_out
);

  localparam logic [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0] HALF = ONE << (FRAC_BITS - 1);
`ifdef PE_ROUND_EVEN_EN
  localparam logic [IN_W:0] HALF_M1 = HALF - ONE;
`endif

  logic signed [IN_W:0]    ext;
  logic signed [IN_W:0]    biased;
  logic signed [IN_W:0]    shifted;
  logic [IN_W-OUT_W+1:0]   hi;

  // One extra MSB keeps the rounding bias from wrapping the most positive value;
  // the result fits when every bit above the output sign matches it.
  always_comb begin
    ext = {acc_in[IN_W-1], acc_in};
`ifdef PE_ROUND_EVEN_EN
    biased = ext + HALF_M1 + {{IN_W{1'b0}}, ext[FRAC_BITS]};
`else
    biased = ext + HALF;
`endif
    shifted = biased >>> FRAC_BITS;
    hi      = shifted[IN_W:OUT_W-1];
    sat_out = !((&hi) || !(|hi));
    if (sat_out)
      data_out = shifted[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      data_out = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/pe_mac_acc.sv
// Multiply-accumulate PE: signed product into one of NUM_ACC slots, flush emits the
// rounded/saturated slot through a credit-protected output FIFO. Macro: PE_ROUND_EVEN_EN.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int INT_BITS   = PE_INT_BITS,
  parameter int FRAC_BITS  = PE_FRAC_BITS,
  parameter int NUM_ACC    = PE_NUM_ACC,
  parameter int GUARD_BITS = PE_GUARD_BITS,
  parameter int OUT_DEPTH  = PE_OUT_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0]      in_a,
  input  logic [INT_BITS+FRAC_BITS-1:0]      in_b,
  input  logic [$clog2(NUM_ACC)-1:0]         in_slot,
  input  logic                               in_flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0]      out_data,
  output logic [$clog2(NUM_ACC)-1:0]         out_slot,
  output logic                               out_sat
);

  localparam int W      = INT_BITS + FRAC_BITS;
  localparam int PROD_W = 2 * W;
  localparam int ACC_W  = PROD_W + GUARD_BITS;
  localparam int SLOT_W = $clog2(NUM_ACC);
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

  logic                     accept;
  logic                     pop;
  logic                     push;

  logic                     s1_valid;
  logic                     s1_flush;
  logic [SLOT_W-1:0]        s1_slot;
  logic signed [PROD_W-1:0] s1_prod;

  logic signed [ACC_W-1:0]  acc [NUM_ACC];
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;

  logic                     s2_valid;
  logic [SLOT_W-1:0]        s2_slot;
  logic signed [ACC_W-1:0]  s2_sum;

  logic [W-1:0]             rs_data;
  logic                     rs_sat;

  logic [W-1:0]             data_mem [OUT_DEPTH];
  logic [SLOT_W-1:0]        slot_mem [OUT_DEPTH];
  logic                     sat_mem  [OUT_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         credits;

  assign in_ready  = (credits != CNT_W'(OUT_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = s2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_slot  <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_flush <= in_flush;
        s1_slot  <= in_slot;
        s1_prod  <= $signed(in_a) * $signed(in_b);
      end
    end
  end

  // Read-modify-write completes in S2, so the next beat to the same slot sees the
  // updated value without forwarding. A flush clears the slot and forwards the sum.
  assign prod_ext = {{GUARD_BITS{s1_prod[PROD_W-1]}}, s1_prod};
  assign acc_sum  = acc[s1_slot] + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      s2_valid <= 1'b0;
      s2_slot  <= '0;
      s2_sum   <= '0;
    end else begin
      if (s1_valid) acc[s1_slot] <= s1_flush ? '0 : acc_sum;
      s2_valid <= s1_valid && s1_flush;
      s2_slot  <= s1_slot;
      s2_sum   <= acc_sum;
    end
  end

  pe_round_sat #(
    .IN_W      (ACC_W),
    .OUT_W     (W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc_in   (s2_sum),
    .data_out (rs_data),
    .sat_out  (rs_sat)
  );

  // Credits reserve a FIFO entry at acceptance, so a push never finds the FIFO full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        data_mem[i] <= '0;
        slot_mem[i] <= '0;
        sat_mem[i]  <= 1'b0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= rs_data;
        slot_mem[wr_ptr] <= s2_slot;
        sat_mem[wr_ptr]  <= rs_sat;
        wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept && in_flush, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign out_data = data_mem[rd_ptr];
  assign out_slot = slot_mem[rd_ptr];
  assign out_sat  = sat_mem[rd_ptr];

endmodule
